// File: rtl/machine_solve_scheduler_pkg.sv
// Shared types and sizing helpers for the machine solve scheduler and its neighbours.
package machine_solve_scheduler_pkg;

  localparam int MAX_ROWS       = 4;
  localparam int MAX_COLS       = 14;
  localparam int AXI_DATA_WIDTH = 8;
  localparam int TOTAL_W        = 32;

  localparam int MAX_VARS_COUNT   = MAX_COLS - 1;
  localparam int MAX_ROWS_W       = $clog2(MAX_ROWS + 1);
  localparam int MAX_COLS_W       = $clog2(MAX_COLS + 1);
  localparam int MAX_VARS_COUNT_W = $clog2(MAX_VARS_COUNT + 1);

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int MAX_BEATS = (ceil_div(MAX_VARS_COUNT, AXI_DATA_WIDTH) < 1) ? 1 :
                             ceil_div(MAX_VARS_COUNT, AXI_DATA_WIDTH);
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int VEC_W     = MAX_BEATS * AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    RREF_START,
    RREF_WAIT,
    ENUM_START,
    COLLECT,
    REPORT,
    DONE
  } state_t;

endpackage

// File: rtl/machine_solve_scheduler_popcount.sv
// Combinational population count over an MAX_N-bit vector.
module machine_solve_scheduler_popcount #(
  parameter int MAX_N = 13
) (
  input  logic [MAX_N-1:0]               vec,
  output logic [$clog2(MAX_N + 1)-1:0]   count
);
  localparam int CW = $clog2(MAX_N + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < MAX_N; i++) begin
      count = count + CW'(vec[i]);
    end
  end
endmodule

// File: rtl/machine_solve_scheduler.sv
// Runs one GF(2) machine through rref and enumeration, tracks the min-popcount solution
// and accumulates the total. Optional MACHINE_SOLVE_STATS_EN adds sol_count/cycles_busy.
//
// state      | meaning
// IDLE       | waiting for mach_valid
// RREF_START | one-cycle start pulse to gf2_rref
// RREF_WAIT  | waiting for rref_done
// ENUM_START | one-cycle start pulse to enumerate_solutions
// COLLECT    | accepting solution beats, tracking minimum
// REPORT     | one-cycle min_valid, total updated
// DONE       | final machine reported, total_valid held until reset
module machine_solve_scheduler
  import machine_solve_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mach_valid,
  input  logic                        mach_last,
  output logic                        mach_ready,
  input  logic [MAX_ROWS_W-1:0]       rows,
  input  logic [MAX_COLS_W-1:0]       cols,
  output logic                        rref_start,
  input  logic                        rref_done,
  output logic                        enum_start,
  input  logic                        sol_tvalid,
  output logic                        sol_tready,
  input  logic [AXI_DATA_WIDTH-1:0]   sol_tdata,
  input  logic                        sol_tlast,
  output logic                        min_valid,
  output logic [MAX_VARS_COUNT_W-1:0] min_presses,
  output logic                        total_valid,
  output logic [TOTAL_W-1:0]          total_presses,
  output logic                        proto_err
`ifdef MACHINE_SOLVE_STATS_EN
  ,
  output logic [MAX_VARS_COUNT:0]     sol_count,
  output logic [31:0]                 cycles_busy
`endif
);

  state_t                      state_q, state_d;
  logic [MAX_ROWS_W-1:0]       rows_q;
  logic [MAX_COLS_W-1:0]       cols_q, vars;
  logic                        last_q;
  logic [BEAT_W-1:0]           beat_idx, beat_last_idx;
  logic [VEC_W-1:0]            vec_q, vec_next;
  logic [MAX_VARS_COUNT-1:0]   masked;
  logic [MAX_VARS_COUNT_W-1:0] pc, cur_min, cur_min_next, min_hold;
  logic [TOTAL_W-1:0]          total_q;
  logic                        proto_err_q;
  logic                        final_beat;
  int                          bps_raw;
  logic                        unused_bits;
`ifdef MACHINE_SOLVE_STATS_EN
  logic [MAX_VARS_COUNT:0]     sol_cnt_q;
  logic [31:0]                 busy_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mach_ready  = 1'b0;
    rref_start  = 1'b0;
    enum_start  = 1'b0;
    sol_tready  = 1'b0;
    min_valid   = 1'b0;
    total_valid = 1'b0;
    case (state_q)
      IDLE: if (mach_valid) begin
        mach_ready = 1'b1;
        state_d    = RREF_START;
      end
      RREF_START: begin
        rref_start = 1'b1;
        state_d    = RREF_WAIT;
      end
      RREF_WAIT:  if (rref_done) state_d = ENUM_START;
      ENUM_START: begin
        enum_start = 1'b1;
        state_d    = COLLECT;
      end
      COLLECT: begin
        sol_tready = 1'b1;
        if (sol_tvalid && sol_tlast) state_d = REPORT;
      end
      REPORT: begin
        min_valid = 1'b1;
        state_d   = last_q ? DONE : IDLE;
      end
      DONE:    total_valid = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Vector reassembly: the current beat is merged combinationally so the final beat
  // contributes to the popcount in the cycle it arrives.
  always_comb begin
    vars          = (cols_q == '0) ? '0 : cols_q - 1'b1;
    bps_raw       = ceil_div(int'(vars), AXI_DATA_WIDTH);
    beat_last_idx = BEAT_W'((bps_raw == 0) ? 0 : bps_raw - 1);
    final_beat    = (beat_idx == beat_last_idx);
    vec_next      = vec_q;
    for (int b = 0; b < MAX_BEATS; b++) begin
      if (beat_idx == BEAT_W'(b)) vec_next[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = sol_tdata;
    end
    for (int i = 0; i < MAX_VARS_COUNT; i++) begin
      masked[i] = vec_next[i] & (MAX_COLS_W'(i) < vars);
    end
    cur_min_next = (pc < cur_min) ? pc : cur_min;
  end

  machine_solve_scheduler_popcount #(.MAX_N(MAX_VARS_COUNT)) u_popcount (
    .vec   (masked),
    .count (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_q      <= '0;
      cols_q      <= '0;
      last_q      <= 1'b0;
      beat_idx    <= '0;
      vec_q       <= '0;
      cur_min     <= '1;
      min_hold    <= '1;
      total_q     <= '0;
      proto_err_q <= 1'b0;
`ifdef MACHINE_SOLVE_STATS_EN
      sol_cnt_q   <= '0;
      busy_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (mach_valid) begin
          rows_q <= rows;
          cols_q <= cols;
          last_q <= mach_last;
        end
        ENUM_START: begin
          beat_idx <= '0;
          cur_min  <= '1;
`ifdef MACHINE_SOLVE_STATS_EN
          sol_cnt_q <= '0;
`endif
        end
        COLLECT: if (sol_tvalid) begin
          vec_q <= vec_next;
          if (final_beat) begin
            cur_min  <= cur_min_next;
            beat_idx <= '0;
`ifdef MACHINE_SOLVE_STATS_EN
            sol_cnt_q <= sol_cnt_q + 1'b1;
`endif
          end else begin
            beat_idx <= beat_idx + 1'b1;
            if (sol_tlast) proto_err_q <= 1'b1;
          end
        end
        REPORT: begin
          total_q  <= total_q + TOTAL_W'(cur_min);
          min_hold <= cur_min;
        end
        default: ;
      endcase
`ifdef MACHINE_SOLVE_STATS_EN
      if (state_q != IDLE && state_q != DONE && busy_q != '1) busy_q <= busy_q + 1'b1;
`endif
    end
  end

  assign min_presses   = (state_q == REPORT) ? cur_min : min_hold;
  assign total_presses = total_q;
  assign proto_err     = proto_err_q;
`ifdef MACHINE_SOLVE_STATS_EN
  assign sol_count     = sol_cnt_q;
  assign cycles_busy   = busy_q;
`endif

  // Row count is carried for the rref block's benefit only; bits above vars never count.
  assign unused_bits = ^{rows_q, vec_next[VEC_W-1:MAX_VARS_COUNT]};

endmodule
